// File: rtl/gfp8_result_packer_if.sv
// Packed FP16 result word toward the result-BRAM writer.
// master drives the word and valid; slave drives ready.
interface gfp8_result_packer_if #(parameter int LANES = 4);
  logic [16*LANES-1:0] data;
  logic [LANES-1:0]    lane_mask;
  logic                last;
  logic                valid;
  logic                ready;

  modport master (output data, lane_mask, last, valid, input ready);
  modport slave  (input data, lane_mask, last, valid, output ready);
endinterface

// File: rtl/gfp8_result_packer.sv
// BCV (mant, 2^exp) results -> FP16, LANES per word, FIFO out. Latency 3 cycles to push, +1 to valid.
// Input stream never stalls; output is valid/ready, a push into a full FIFO without a pop is dropped.
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  input  logic         i_push,
  input  logic [W-1:0] i_push_dat,
  output logic         o_push_rdy,
  output logic         o_pop_vld,
  output logic [W-1:0] o_pop_dat,
  input  logic         i_pop_rdy
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_cnt;
  logic          w_pop, w_wr;

  assign o_pop_vld  = (r_cnt != '0);
  assign o_pop_dat  = r_mem[r_rd_ptr];
  assign w_pop      = o_pop_vld && i_pop_rdy;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign o_push_rdy = (r_cnt != FULL_CNT) || w_pop;
  assign w_wr       = i_push && o_push_rdy;

  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_push_dat;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_wr, w_pop})
        2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end
endmodule

module gfp8_result_packer #(
  parameter int LANES      = 4,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                       i_clk,
  input  logic                       i_reset_n,
  input  logic signed [31:0]         i_result_mantissa,
  input  logic signed [7:0]          i_result_exponent,
  input  logic                       i_result_valid,
  input  logic                       i_tile_done,
  input  logic                       i_clear_err,
  gfp8_result_packer_if.master       m_word,
  output logic [15:0]                o_tile_count,
  output logic                       o_overflow_err,
  output logic                       o_sat_flag
);
  localparam int PW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int WW = 16*LANES + LANES + 1;
  localparam logic [PW-1:0] LANE_MAX = PW'(LANES-1);

  // S1: sign, magnitude, MSB position
  logic [32:0]       w_mag;
  logic [4:0]        w_pos;
  logic              r_s1_vld, r_s1_done, r_s1_sign;
  logic [32:0]       r_s1_mag;
  logic [4:0]        r_s1_pos;
  logic signed [7:0] r_s1_exp;

  always_comb begin
    w_mag = i_result_mantissa[31] ? (33'd0 - {1'b1, i_result_mantissa})
                                  : {1'b0, i_result_mantissa};
    w_pos = '0;
    for (int i = 0; i < 32; i++) if (w_mag[i]) w_pos = i[4:0];
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_s1_vld <= 1'b0; r_s1_done <= 1'b0; r_s1_sign <= 1'b0;
      r_s1_mag <= '0;   r_s1_pos  <= '0;   r_s1_exp  <= '0;
    end else begin
      r_s1_vld  <= i_result_valid;
      r_s1_done <= i_tile_done;
      r_s1_sign <= i_result_mantissa[31];
      r_s1_mag  <= w_mag;
      r_s1_pos  <= w_pos;
      r_s1_exp  <= i_result_exponent;
    end
  end

  // S2: normalise so the leading one drops off bit 31, round to nearest-even
  logic [30:0]       w_norm;
  logic              w_rnd, w_zero, w_sat;
  logic [10:0]       w_frac_r;
  logic signed [9:0] w_e;
  logic [15:0]       w_fp;
  logic              r_s2_vld, r_s2_done;
  logic [15:0]       r_s2_fp;

  always_comb begin
    w_norm   = 31'(r_s1_mag[31:0] << (5'd31 - r_s1_pos));
    w_rnd    = w_norm[20] & ((|w_norm[19:0]) | w_norm[21]);
    w_frac_r = {1'b0, w_norm[30:21]} + {10'd0, w_rnd};
    w_e      = {5'd0, r_s1_pos} + {{2{r_s1_exp[7]}}, r_s1_exp} + 10'd15
             + {9'd0, w_frac_r[10]};
    w_zero   = (r_s1_mag == 33'd0);
    w_sat    = r_s1_vld && !w_zero && (w_e >= 10'sd31);
    if (w_zero || w_e <= 10'sd0) w_fp = 16'h0000;
    else if (w_e >= 10'sd31)     w_fp = {r_s1_sign, 15'h7BFF};
    else                         w_fp = {r_s1_sign, w_e[4:0], w_frac_r[9:0]};
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_s2_vld <= 1'b0; r_s2_done <= 1'b0; r_s2_fp <= '0;
    end else begin
      r_s2_vld  <= r_s1_vld;
      r_s2_done <= r_s1_done;
      r_s2_fp   <= w_fp;
    end
  end

  // Pack: accumulate lanes, emit on full word or tile end
  logic [16*LANES-1:0] r_acc, w_acc, r_pk_dat;
  logic [LANES-1:0]    w_mask, r_pk_mask;
  logic [PW-1:0]       r_ptr;
  logic [PW:0]         w_fill;
  logic                w_push, r_pk_vld, r_pk_last;

  always_comb begin
    w_acc = r_acc;
    for (int k = 0; k < LANES; k++)
      if (r_s2_vld && r_ptr == PW'(k)) w_acc[16*k +: 16] = r_s2_fp;
    w_fill = {1'b0, r_ptr} + {{PW{1'b0}}, r_s2_vld};
    for (int k = 0; k < LANES; k++) w_mask[k] = ((PW+1)'(k) < w_fill);
    w_push = r_s2_done || (r_s2_vld && r_ptr == LANE_MAX);
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_acc <= '0; r_ptr <= '0; r_pk_vld <= 1'b0;
      r_pk_dat <= '0; r_pk_mask <= '0; r_pk_last <= 1'b0;
    end else begin
      r_pk_vld <= w_push;
      if (w_push) begin
        r_pk_dat  <= w_acc;
        r_pk_mask <= w_mask;
        r_pk_last <= r_s2_done;
        r_acc     <= '0;
        r_ptr     <= '0;
      end else begin
        r_acc <= w_acc;
        if (r_s2_vld) r_ptr <= r_ptr + PW'(1);
      end
    end
  end

  logic          w_fifo_rdy, w_fifo_vld, w_drop;
  logic [WW-1:0] w_fifo_dat;

  sync_fifo #(.W(WW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .i_push     (r_pk_vld),
    .i_push_dat ({r_pk_last, r_pk_mask, r_pk_dat}),
    .o_push_rdy (w_fifo_rdy),
    .o_pop_vld  (w_fifo_vld),
    .o_pop_dat  (w_fifo_dat),
    .i_pop_rdy  (m_word.ready)
  );

  assign w_drop           = r_pk_vld && !w_fifo_rdy;
  assign m_word.valid     = w_fifo_vld;
  assign m_word.data      = w_fifo_vld ? w_fifo_dat[16*LANES-1:0] : '0;
  assign m_word.lane_mask = w_fifo_vld ? w_fifo_dat[16*LANES +: LANES] : '0;
  assign m_word.last      = w_fifo_vld && w_fifo_dat[WW-1];

  // Count shows the done-cycle total for one cycle before restarting
  logic        r_cnt_clr;
  logic [15:0] w_cnt_base;
  assign w_cnt_base = r_cnt_clr ? 16'd0 : o_tile_count;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_tile_count   <= '0;
      r_cnt_clr      <= 1'b0;
      o_overflow_err <= 1'b0;
      o_sat_flag     <= 1'b0;
    end else begin
      r_cnt_clr <= i_tile_done;
      if (i_result_valid && w_cnt_base != 16'hFFFF) o_tile_count <= w_cnt_base + 16'd1;
      else                                          o_tile_count <= w_cnt_base;
      o_overflow_err <= w_drop | (o_overflow_err & ~i_clear_err);
      o_sat_flag     <= w_sat  | (o_sat_flag & ~i_clear_err);
    end
  end
endmodule

// File: tb/tb_gfp8_result_packer.sv
// Directed bench for gfp8_result_packer: FP16 conversion, lane packing, tile close, FIFO overflow, reset.
module tb_gfp8_result_packer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n, vld, done, clr;
  logic signed [31:0] mant;
  logic signed [7:0]  expo;
  logic [15:0]        tile_cnt;
  logic               ovf, sat;
  int                 n_chk = 0, n_err = 0;

  gfp8_result_packer_if #(.LANES(4)) word_if();

  gfp8_result_packer #(.LANES(4), .FIFO_DEPTH(16)) dut (
    .i_clk             (clk),
    .i_reset_n         (rst_n),
    .i_result_mantissa (mant),
    .i_result_exponent (expo),
    .i_result_valid    (vld),
    .i_tile_done       (done),
    .i_clear_err       (clr),
    .m_word            (word_if),
    .o_tile_count      (tile_cnt),
    .o_overflow_err    (ovf),
    .o_sat_flag        (sat)
  );

  typedef struct { logic [63:0] d; logic [3:0] m; logic l; } word_t;
  word_t q[$];

  always @(negedge clk)
    if (rst_n && word_if.valid && word_if.ready)
      q.push_back('{word_if.data, word_if.lane_mask, word_if.last});

  task automatic chk(string tag, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %h want %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drive(logic signed [31:0] m, logic signed [7:0] e, logic v, logic d);
    mant = m; expo = e; vld = v; done = d;
    step();
    mant = '0; expo = '0; vld = 1'b0; done = 1'b0;
  endtask

  task automatic get_word(string tag, output word_t w);
    for (int i = 0; i < 40 && q.size() == 0; i++) step();
    chk({tag, "_arrive"}, 64'(q.size() != 0), 64'd1);
    if (q.size() != 0) w = q.pop_front();
    else               w = '{d: '0, m: '0, l: 1'b0};
  endtask

  // lane k carries mantissa k+1 scaled by 2^e
  function automatic logic [15:0] ref_fp(int k, int e);
    case (k)
      0:       return 16'((15 + e) << 10);
      1:       return 16'((16 + e) << 10);
      2:       return 16'(((16 + e) << 10) | 16'h200);
      default: return 16'((17 + e) << 10);
    endcase
  endfunction

  initial begin
    word_t w;
    logic [63:0] exp_d;
    rst_n = 1'b0; mant = '0; expo = '0; vld = 1'b0; done = 1'b0; clr = 1'b0;
    word_if.ready = 1'b1;
    step(); step();
    chk("rst_valid", 64'(word_if.valid), 64'd0);
    chk("rst_data",  word_if.data, 64'd0);
    chk("rst_cnt",   64'(tile_cnt), 64'd0);
    chk("rst_ovf",   64'(ovf), 64'd0);
    chk("rst_sat",   64'(sat), 64'd0);
    rst_n = 1'b1;
    step();

    // 1: four lanes incl. rounding carry
    drive(32'sd1, 8'sd0, 1'b1, 1'b0);
    drive(-32'sd3, -8'sd1, 1'b1, 1'b0);
    drive(32'sd2047, 8'sd0, 1'b1, 1'b0);
    drive(32'sd4095, 8'sd0, 1'b1, 1'b1);
    chk("t1_cnt_done", 64'(tile_cnt), 64'd4);
    step();
    chk("t1_cnt_clr", 64'(tile_cnt), 64'd0);
    get_word("t1", w);
    chk("t1_data", w.d, 64'h6C00_67FF_BE00_3C00);
    chk("t1_mask", 64'(w.m), 64'hF);
    chk("t1_last", 64'(w.l), 64'd1);

    // 2: saturation, latency, sticky clear
    drive(32'sd1, 8'sd20, 1'b1, 1'b1);
    step(); step();
    chk("t2_lat_early", 64'(word_if.valid), 64'd0);
    step();
    chk("t2_lat_valid", 64'(word_if.valid), 64'd1);
    get_word("t2a", w);
    chk("t2a_data", w.d, 64'h7BFF);
    chk("t2a_mask", 64'(w.m), 64'h1);
    chk("t2a_last", 64'(w.l), 64'd1);
    chk("t2_sat_set", 64'(sat), 64'd1);
    clr = 1'b1; step(); clr = 1'b0;
    chk("t2_sat_clr", 64'(sat), 64'd0);
    drive(-32'sd1, 8'sd20, 1'b1, 1'b1);
    get_word("t2b", w);
    chk("t2b_data", w.d, 64'hFBFF);

    // 3: underflow, zero, most-negative mantissa, partial word
    drive(32'sd1, -8'sd15, 1'b1, 1'b0);
    drive(32'sd0, 8'sd0, 1'b1, 1'b0);
    drive(32'sh8000_0000, -8'sd31, 1'b1, 1'b1);
    get_word("t3", w);
    chk("t3_data", w.d, 64'h0000_BC00_0000_0000);
    chk("t3_mask", 64'(w.m), 64'h7);
    chk("t3_last", 64'(w.l), 64'd1);
    drive(32'sh8000_0000, -8'sd16, 1'b1, 1'b1);
    get_word("t3b", w);
    chk("t3b_data", w.d, 64'hF800);
    drive(32'sd0, 8'sd0, 1'b0, 1'b1);
    get_word("t3c", w);
    chk("t3c_data", w.d, 64'd0);
    chk("t3c_mask", 64'(w.m), 64'h0);
    chk("t3c_last", 64'(w.l), 64'd1);

    // 4: ten back-to-back results
    for (int i = 1; i <= 10; i++) drive(32'(i), 8'sd0, 1'b1, i == 10);
    chk("t4_cnt_done", 64'(tile_cnt), 64'd10);
    step();
    chk("t4_cnt_clr", 64'(tile_cnt), 64'd0);
    get_word("t4w0", w);
    chk("t4w0_data", w.d, 64'h4400_4200_4000_3C00);
    chk("t4w0_mask", 64'(w.m), 64'hF);
    chk("t4w0_last", 64'(w.l), 64'd0);
    get_word("t4w1", w);
    chk("t4w1_data", w.d, 64'h4800_4700_4600_4500);
    chk("t4w1_mask", 64'(w.m), 64'hF);
    chk("t4w1_last", 64'(w.l), 64'd0);
    get_word("t4w2", w);
    chk("t4w2_data", w.d, 64'h0000_0000_4900_4880);
    chk("t4w2_mask", 64'(w.m), 64'h3);
    chk("t4w2_last", 64'(w.l), 64'd1);

    // 5: fill FIFO with ready low, 17th word dropped
    clr = 1'b1; step(); clr = 1'b0;
    word_if.ready = 1'b0;
    for (int wi = 0; wi < 17; wi++)
      for (int k = 0; k < 4; k++) drive(32'(k + 1), 8'(wi - 8), 1'b1, 1'b0);
    chk("t5_cnt", 64'(tile_cnt), 64'd68);
    for (int i = 0; i < 5; i++) step();
    chk("t5_ovf", 64'(ovf), 64'd1);
    chk("t5_sat", 64'(sat), 64'd0);
    chk("t5_hold_valid", 64'(word_if.valid), 64'd1);
    chk("t5_hold_data", word_if.data,
        {ref_fp(3, -8), ref_fp(2, -8), ref_fp(1, -8), ref_fp(0, -8)});
    word_if.ready = 1'b1;
    for (int wi = 0; wi < 16; wi++) begin
      get_word("t5w", w);
      exp_d = {ref_fp(3, wi - 8), ref_fp(2, wi - 8), ref_fp(1, wi - 8), ref_fp(0, wi - 8)};
      chk($sformatf("t5w%0d_data", wi), w.d, exp_d);
      chk($sformatf("t5w%0d_mask", wi), 64'(w.m), 64'hF);
    end
    for (int i = 0; i < 5; i++) step();
    chk("t5_no_extra", 64'(q.size()), 64'd0);
    clr = 1'b1; step(); clr = 1'b0;
    chk("t5_ovf_clr", 64'(ovf), 64'd0);

    // 6: reset mid-tile with pending lanes and queued words
    word_if.ready = 1'b0;
    for (int i = 0; i < 14; i++) drive(32'sd7, 8'sd0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step();
    chk("t6_pre_valid", 64'(word_if.valid), 64'd1);
    rst_n = 1'b0; #1;
    chk("t6_rst_valid", 64'(word_if.valid), 64'd0);
    chk("t6_rst_cnt", 64'(tile_cnt), 64'd0);
    chk("t6_rst_data", word_if.data, 64'd0);
    step();
    rst_n = 1'b1;
    word_if.ready = 1'b1;
    step();
    drive(32'sd1, 8'sd0, 1'b1, 1'b1);
    get_word("t6", w);
    chk("t6_data", w.d, 64'h3C00);
    chk("t6_mask", 64'(w.m), 64'h1);
    chk("t6_last", 64'(w.l), 64'd1);
    for (int i = 0; i < 5; i++) step();
    chk("t6_no_extra", 64'(q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
